// File: rtl/refresh_interleaver.sv
// -----------------------------------------------------------------------------
// refresh_interleaver
//
// Refresh command generator for the DIMM model. A free-running interval
// counter accumulates refresh debt, one unit per TREFI enabled cycles, up to
// MAXPOSTPONE. When debt is outstanding and the controller is idle (or the
// debt has saturated), a sweep is started. A sweep is either a single
// all-bank REF or a sequence of per-bank REFs covering every bank group and
// bank, followed by a recovery window. Commands are offered to the command
// mux through a valid/ready handshake.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   enable        interval counting and new sweeps allowed
//   mode          0 = all-bank REF, 1 = per-bank sweep (latched at sweep start)
//   busy          controller busy; defers non-urgent sweeps
//   cmd_valid     REF command presented
//   cmd_ready     command accepted when high together with cmd_valid
//   cmd_bg        target bank group
//   cmd_ba        target bank
//   cmd_A         REF_ENC while cmd_valid, else 0
//   cmd_allbank   1 for an all-bank REF
//   debt          outstanding refreshes
//   urgent        debt has reached MAXPOSTPONE
//   overflow      sticky: an interval expired while debt was saturated
//   sweep_active  high from sweep start until the end of recovery
// -----------------------------------------------------------------------------
module refresh_interleaver #(
  parameter int                   BGWIDTH     = 2,
  parameter int                   BAWIDTH     = 2,
  parameter int                   ADDRWIDTH   = 17,
  parameter logic [ADDRWIDTH-1:0] REF_ENC     = 17'b00100000000000001,
  parameter int                   TREFI       = 5200,
  parameter int                   TRRD        = 4,
  parameter int                   TRFC_PB     = 120,
  parameter int                   TRFC_AB     = 260,
  parameter int                   MAXPOSTPONE = 8,
  parameter int                   ORDER       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 mode,
  input  logic                                 busy,
  output logic                                 cmd_valid,
  input  logic                                 cmd_ready,
  output logic [BGWIDTH-1:0]                   cmd_bg,
  output logic [BAWIDTH-1:0]                   cmd_ba,
  output logic [ADDRWIDTH-1:0]                 cmd_A,
  output logic                                 cmd_allbank,
  output logic [$clog2(MAXPOSTPONE+1)-1:0]     debt,
  output logic                                 urgent,
  output logic                                 overflow,
  output logic                                 sweep_active
);

  localparam int IDXW  = BGWIDTH + BAWIDTH;
  localparam int CNTW  = (TREFI > 2) ? $clog2(TREFI) : 1;
  localparam int DEBTW = $clog2(MAXPOSTPONE + 1);
  localparam int TRFC_MAX = (TRFC_AB > TRFC_PB) ? TRFC_AB : TRFC_PB;
  localparam int TMAX  = (TRFC_MAX > TRRD) ? TRFC_MAX : TRRD;
  localparam int TW    = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(TREFI - 1);
  localparam logic [DEBTW-1:0] DEBT_MAX = DEBTW'(MAXPOSTPONE);
  // Timers are loaded with N-1 so that the state lasts exactly N cycles.
  localparam logic [TW-1:0]    GAP_INIT = TW'((TRRD    > 0) ? TRRD    - 1 : 0);
  localparam logic [TW-1:0]    PB_INIT  = TW'((TRFC_PB > 0) ? TRFC_PB - 1 : 0);
  localparam logic [TW-1:0]    AB_INIT  = TW'((TRFC_AB > 0) ? TRFC_AB - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    GAP     = 2'd2,
    RECOVER = 2'd3
  } state_e;

  // State registers and their next-state values
  state_e               state_q,     state_d;
  logic [CNTW-1:0]      cnt_q,       cnt_d;
  logic [IDXW-1:0]      idx_q,       idx_d;
  logic [TW-1:0]        timer_q,     timer_d;
  logic                 mode_q,      mode_d;
  logic [DEBTW-1:0]     debt_q,      debt_d;
  logic                 overflow_q,  overflow_d;
  logic                 urgent_q,    urgent_d;

  // Registered command outputs
  logic                 valid_q,     valid_d;
  logic [BGWIDTH-1:0]   bg_q,        bg_d;
  logic [BAWIDTH-1:0]   ba_q,        ba_d;
  logic [ADDRWIDTH-1:0] a_q,         a_d;
  logic                 allbank_q,   allbank_d;
  logic                 active_q,    active_d;

  logic                 tick;
  logic                 accept;
  logic                 last_bank;
  logic                 sweep_done;
  logic                 start;
  logic [TW-1:0]        rec_init;
  logic                 rec_zero;

  // ---------------------------------------------------------------------------
  // Interval counter: one tick every TREFI enabled cycles.
  // ---------------------------------------------------------------------------
  assign tick  = enable && (cnt_q == CNT_LAST);
  assign cnt_d = !enable ? cnt_q :
                 tick    ? '0    : cnt_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Handshake and sweep bookkeeping. cmd_valid is exactly "state is ISSUE",
  // so acceptance can be derived from the state register directly.
  // ---------------------------------------------------------------------------
  assign accept     = (state_q == ISSUE) && cmd_ready;
  assign last_bank  = (idx_q == {IDXW{1'b1}});
  assign sweep_done = accept && (!mode_q || last_bank);
  assign start      = (state_q == IDLE) && enable && (debt_q != '0) &&
                      (!busy || urgent_q);

  assign rec_init = mode_q ? PB_INIT : AB_INIT;
  assign rec_zero = mode_q ? (TRFC_PB == 0) : (TRFC_AB == 0);

  // ---------------------------------------------------------------------------
  // Debt accounting. A tick and a sweep completion in the same cycle cancel,
  // so that case neither changes debt nor counts as an overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    debt_d     = debt_q;
    overflow_d = overflow_q;
    if (tick && !sweep_done) begin
      if (debt_q == DEBT_MAX) overflow_d = 1'b1;
      else                    debt_d     = debt_q + 1'b1;
    end else if (sweep_done && !tick) begin
      debt_d = debt_q - 1'b1;
    end
  end

  assign urgent_d = (debt_d == DEBT_MAX);

  // ---------------------------------------------------------------------------
  // Sweep FSM next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          mode_d  = mode;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (sweep_done) begin
            if (rec_zero) begin
              state_d = IDLE;
            end else begin
              state_d = RECOVER;
              timer_d = rec_init;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            // With no spacing required the next bank is offered immediately.
            if (TRRD == 0) begin
              state_d = ISSUE;
            end else begin
              state_d = GAP;
              timer_d = GAP_INIT;
            end
          end
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = ISSUE;
        else               timer_d = timer_q - 1'b1;
      end
      RECOVER: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command outputs, computed from next-state so they can be registered and
  // still line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d   = (state_d == ISSUE);
    bg_d      = '0;
    ba_d      = '0;
    a_d       = '0;
    allbank_d = 1'b0;
    if (valid_d) begin
      a_d = REF_ENC;
      if (!mode_d) begin
        allbank_d = 1'b1;
      end else if (ORDER == 0) begin
        // Bank address varies fastest within a bank group.
        bg_d = idx_d[IDXW-1:BAWIDTH];
        ba_d = idx_d[BAWIDTH-1:0];
      end else begin
        // Bank group varies fastest for a given bank address.
        ba_d = idx_d[IDXW-1:BGWIDTH];
        bg_d = idx_d[BGWIDTH-1:0];
      end
    end
  end

  assign active_d = (state_d != IDLE);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch covers every register.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      mode_q     <= 1'b0;
      debt_q     <= '0;
      overflow_q <= 1'b0;
      urgent_q   <= 1'b0;
      valid_q    <= 1'b0;
      bg_q       <= '0;
      ba_q       <= '0;
      a_q        <= '0;
      allbank_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mode_q     <= mode_d;
      debt_q     <= debt_d;
      overflow_q <= overflow_d;
      urgent_q   <= urgent_d;
      valid_q    <= valid_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      allbank_q  <= allbank_d;
      active_q   <= active_d;
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_bg       = bg_q;
  assign cmd_ba       = ba_q;
  assign cmd_A        = a_q;
  assign cmd_allbank  = allbank_q;
  assign debt         = debt_q;
  assign urgent       = urgent_q;
  assign overflow     = overflow_q;
  assign sweep_active = active_q;

endmodule

// File: tb/tb_refresh_interleaver.sv
// -----------------------------------------------------------------------------
// tb_refresh_interleaver
//
// Two instances (ORDER=0 and ORDER=1) share one stimulus stream. Each has a
// timestamp-based reference model: refresh ticks come from counting enabled
// cycles, command slots from "next command due at cycle N", and recovery from
// "sweep ends at cycle N". Every output of both instances is compared against
// the model on each falling edge, with a few directed checks on top.
// -----------------------------------------------------------------------------
module tb_refresh_interleaver;

  localparam int TREFI   = 20;
  localparam int TRRD    = 2;
  localparam int TRFC_PB = 10;
  localparam int TRFC_AB = 30;
  localparam int MAXP    = 4;
  localparam int NBG     = 4;
  localparam int NBA     = 4;
  localparam int NBANKS  = NBG * NBA;
  localparam int DW      = $clog2(MAXP + 1);
  localparam logic [16:0] REF_A = 17'h04001;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic enable    = 1'b0;
  logic mode      = 1'b1;
  logic busy      = 1'b0;
  logic cmd_ready = 1'b1;
  bit   checking_on = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic           cmd_valid, cmd_allbank, urgent, overflow, sweep_active;
    logic [1:0]     cmd_bg, cmd_ba;
    logic [16:0]    cmd_A;
    logic [DW-1:0]  debt;

    refresh_interleaver #(
      .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .REF_ENC(17'b00100000000000001),
      .TREFI(TREFI), .TRRD(TRRD), .TRFC_PB(TRFC_PB), .TRFC_AB(TRFC_AB),
      .MAXPOSTPONE(MAXP), .ORDER(g)
    ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bg(cmd_bg),
      .cmd_ba(cmd_ba), .cmd_A(cmd_A), .cmd_allbank(cmd_allbank),
      .debt(debt), .urgent(urgent), .overflow(overflow),
      .sweep_active(sweep_active)
    );

    // ---- reference model ----
    int cyc        = 0;   // index of the current cycle
    int ecount     = 0;   // enabled cycles since reset
    int m_debt     = 0;
    bit m_ovf      = 0;
    bit in_sweep   = 0;
    bit recovering = 0;
    bit m_mode     = 0;
    int m_k        = 0;   // per-bank commands already accepted in this sweep
    int present_at = 0;   // first cycle the next command is due
    int end_at     = 0;   // first idle cycle after recovery

    function automatic bit exp_valid();
      return in_sweep && !recovering && (cyc >= present_at);
    endfunction

    always @(posedge clk) begin
      if (rst) begin
        ecount = 0; m_debt = 0; m_ovf = 0;
        in_sweep = 0; recovering = 0; m_k = 0;
        cyc++;
      end else begin
        bit tick, acc, fin, st;
        tick = enable && (((ecount + 1) % TREFI) == 0);
        if (enable) ecount++;
        acc = exp_valid() && cmd_ready;
        fin = acc && (!m_mode || m_k == NBANKS - 1);
        st  = !in_sweep && enable && (m_debt > 0) && (!busy || m_debt == MAXP);
        if (tick && !fin) begin
          if (m_debt == MAXP) m_ovf = 1;
          else                m_debt++;
        end else if (fin && !tick) begin
          m_debt--;
        end
        if (acc) begin
          if (fin) begin
            recovering = 1;
            end_at = cyc + 1 + (m_mode ? TRFC_PB : TRFC_AB);
          end else begin
            m_k++;
            present_at = cyc + 1 + TRRD;
          end
        end
        if (st) begin
          in_sweep = 1; recovering = 0; m_mode = mode; m_k = 0;
          present_at = cyc + 1;
        end
        cyc++;
        if (recovering && cyc == end_at) begin
          in_sweep = 0; recovering = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (checking_on) begin
        bit v;
        int ebg, eba;
        v = exp_valid();
        ebg = 0; eba = 0;
        if (v && m_mode) begin
          if (g == 0) begin ebg = m_k / NBA; eba = m_k % NBA; end
          else        begin ebg = m_k % NBG; eba = m_k / NBG; end
        end
        check_eq($sformatf("valid%0d", g),   32'(cmd_valid),    32'(v));
        check_eq($sformatf("bg%0d", g),      32'(cmd_bg),       32'(ebg));
        check_eq($sformatf("ba%0d", g),      32'(cmd_ba),       32'(eba));
        check_eq($sformatf("A%0d", g),       32'(cmd_A),        v ? 32'(REF_A) : 32'd0);
        check_eq($sformatf("allbank%0d", g), 32'(cmd_allbank),  32'(v && !m_mode));
        check_eq($sformatf("debt%0d", g),    32'(debt),         32'(m_debt));
        check_eq($sformatf("urgent%0d", g),  32'(urgent),       32'(m_debt == MAXP));
        check_eq($sformatf("overflow%0d", g),32'(overflow),     32'(m_ovf));
        check_eq($sformatf("active%0d", g),  32'(sweep_active), 32'(in_sweep));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit found;

    // ---- reset state ----
    step();
    step();
    checking_on = 1'b1;
    for (int g = 0; g < 2; g++) begin
      check_eq("rst_valid",  32'(g == 0 ? gen_dut[0].cmd_valid    : gen_dut[1].cmd_valid),    32'd0);
      check_eq("rst_debt",   32'(g == 0 ? gen_dut[0].debt         : gen_dut[1].debt),         32'd0);
      check_eq("rst_active", 32'(g == 0 ? gen_dut[0].sweep_active : gen_dut[1].sweep_active), 32'd0);
    end
    rst = 1'b0;

    // ---- per-bank sweeps, always ready ----
    enable = 1'b1; mode = 1'b1; busy = 1'b0; cmd_ready = 1'b1;
    repeat (140) step();

    // ---- stall the 3rd per-bank command for 7 cycles ----
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (gen_dut[0].in_sweep && !gen_dut[0].recovering && gen_dut[0].m_mode &&
          gen_dut[0].m_k == 2 && gen_dut[0].cyc >= gen_dut[0].present_at)
        found = 1;
      else
        step();
    end
    check_eq("stall_found", 32'(found), 32'd1);
    if (found) begin
      cmd_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
        check_eq("stall_bg0", 32'(gen_dut[0].cmd_bg), 32'd0);
        check_eq("stall_ba0", 32'(gen_dut[0].cmd_ba), 32'd2);
        check_eq("stall_bg1", 32'(gen_dut[1].cmd_bg), 32'd2);
        check_eq("stall_ba1", 32'(gen_dut[1].cmd_ba), 32'd0);
        check_eq("stall_A",   32'(gen_dut[0].cmd_A),  32'(REF_A));
        step();
      end
      cmd_ready = 1'b1;
    end
    repeat (60) step();

    // ---- reset during GAP after 5 REFs ----
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (gen_dut[0].in_sweep && !gen_dut[0].recovering && gen_dut[0].m_mode &&
          gen_dut[0].m_k == 5 && gen_dut[0].cyc < gen_dut[0].present_at)
        found = 1;
      else
        step();
    end
    check_eq("gap_found", 32'(found), 32'd1);
    do_reset();
    check_eq("gaprst_valid",  32'(gen_dut[0].cmd_valid),    32'd0);
    check_eq("gaprst_debt",   32'(gen_dut[0].debt),         32'd0);
    check_eq("gaprst_active", 32'(gen_dut[0].sweep_active), 32'd0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (gen_dut[0].cmd_valid) found = 1;
      else step();
    end
    check_eq("restart_seen", 32'(found), 32'd1);
    check_eq("restart_bg", 32'(gen_dut[0].cmd_bg), 32'd0);
    check_eq("restart_ba", 32'(gen_dut[0].cmd_ba), 32'd0);

    // ---- all-bank sweeps ----
    mode = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (gen_dut[0].cmd_valid && gen_dut[0].cmd_allbank) found = 1;
      else step();
    end
    check_eq("ab_seen", 32'(found), 32'd1);
    check_eq("ab_bg", 32'(gen_dut[0].cmd_bg), 32'd0);
    check_eq("ab_ba", 32'(gen_dut[0].cmd_ba), 32'd0);
    repeat (150) step();

    // ---- busy held, debt saturates, stuck sweep overflows ----
    do_reset();
    mode = 1'b1; busy = 1'b1; cmd_ready = 1'b0;
    repeat (115) step();
    check_eq("sat_debt",     32'(gen_dut[0].debt),         32'(MAXP));
    check_eq("sat_urgent",   32'(gen_dut[0].urgent),       32'd1);
    check_eq("sat_overflow", 32'(gen_dut[0].overflow),     32'd1);
    check_eq("sat_active",   32'(gen_dut[0].sweep_active), 32'd1);
    do_reset();

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      busy      = ($urandom_range(0, 1) == 1);
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
